// File: rtl/fc_l2_port_arbiter.sv
`default_nettype none
// ============================================================================
// fc_l2_port_arbiter : round-robin share of one L2 TCDM master port, with an
//                      in-order ID FIFO routing each response to its issuer.
// Revision: 1.0
// ============================================================================
module fc_l2_port_arbiter #(
  parameter int N_REQ           = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  localparam int BE_WIDTH       = DATA_WIDTH / 8,
  localparam int CNT_WIDTH      = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [N_REQ-1:0]              req_i,
  input  logic [N_REQ*ADDR_WIDTH-1:0]   add_i,
  input  logic [N_REQ-1:0]              wen_i,
  input  logic [N_REQ*DATA_WIDTH-1:0]   wdata_i,
  input  logic [N_REQ*BE_WIDTH-1:0]     be_i,
  output logic [N_REQ-1:0]              gnt_o,
  output logic [N_REQ-1:0]              r_valid_o,
  output logic [DATA_WIDTH-1:0]         r_rdata_o,
  output logic                          r_opc_o,
  output logic                          req_o,
  output logic [ADDR_WIDTH-1:0]         add_o,
  output logic                          wen_o,
  output logic [DATA_WIDTH-1:0]         wdata_o,
  output logic [BE_WIDTH-1:0]           be_o,
  input  logic                          gnt_i,
  input  logic                          r_valid_i,
  input  logic [DATA_WIDTH-1:0]         r_rdata_i,
  input  logic                          r_opc_i,
  output logic [CNT_WIDTH-1:0]          outstanding_o,
  output logic                          err_unexp_rvalid_o
);

  localparam int ID_WIDTH = $clog2(N_REQ);
  localparam int FIFO_AW  = $clog2(MAX_OUTSTANDING);
  localparam logic [CNT_WIDTH-1:0] C_MAX_CNT = CNT_WIDTH'(MAX_OUTSTANDING);

  logic [ID_WIDTH-1:0]  r_ptr;
  logic [ID_WIDTH-1:0]  r_fifo [MAX_OUTSTANDING];
  logic [FIFO_AW-1:0]   r_wptr;
  logic [FIFO_AW-1:0]   r_rptr;
  logic [CNT_WIDTH-1:0] r_count;
  logic                 r_err;

  logic [ID_WIDTH-1:0]  w_winner;
  logic [ID_WIDTH-1:0]  w_idx;
  logic [ID_WIDTH-1:0]  w_ptr_nxt;
  logic [ID_WIDTH-1:0]  w_head;
  int                   w_sum;
  logic                 w_found;
  logic                 w_full;
  logic                 w_push;
  logic                 w_pop;

  // Scan requesters starting at r_ptr; the first one asserting req_i wins.
  always_comb begin : p_rr
    w_winner = '0;
    w_found  = 1'b0;
    w_sum    = 0;
    w_idx    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_sum = int'(r_ptr) + i;
      if (w_sum >= N_REQ) w_sum = w_sum - N_REQ;
      w_idx = ID_WIDTH'(w_sum);
      if (!w_found && req_i[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  assign w_full    = (r_count == C_MAX_CNT);
  assign req_o     = (|req_i) & ~w_full;
  assign w_push    = req_o & gnt_i;
  assign w_head    = r_fifo[r_rptr];
  assign w_pop     = r_valid_i & (r_count != '0);
  assign w_ptr_nxt = (int'(w_winner) == N_REQ - 1) ? '0 : w_winner + 1'b1;

  assign add_o   = req_o ? add_i[int'(w_winner)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign wdata_o = req_o ? wdata_i[int'(w_winner)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign be_o    = req_o ? be_i[int'(w_winner)*BE_WIDTH +: BE_WIDTH] : '0;
  assign wen_o   = req_o ? wen_i[w_winner] : 1'b1;

  always_comb begin : p_route
    gnt_o     = '0;
    r_valid_o = '0;
    if (w_push) gnt_o[w_winner]   = 1'b1;
    if (w_pop)  r_valid_o[w_head] = 1'b1;
  end

  assign r_rdata_o          = r_rdata_i;
  assign r_opc_o            = r_opc_i;
  assign outstanding_o      = r_count;
  assign err_unexp_rvalid_o = r_err;

  // ID storage needs no reset: entries are only read while r_count > 0.
  always_ff @(posedge clk_i) begin : p_fifo_mem
    if (w_push) r_fifo[r_wptr] <= w_winner;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin : p_state
    if (!rst_ni) begin
      r_ptr   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_push) begin
        r_ptr  <= w_ptr_nxt;
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (r_valid_i && (r_count == '0)) r_err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fc_l2_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_fc_l2_port_arbiter : directed + random bench against a queue-based model.
// Revision: 1.0
// ============================================================================
module tb_fc_l2_port_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int MO = 4;
  localparam int CW = $clog2(MO + 1);

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [N-1:0]    req_i = '0;
  logic [N*AW-1:0] add_i = '0;
  logic [N-1:0]    wen_i = '1;
  logic [N*DW-1:0] wdata_i = '0;
  logic [N*BW-1:0] be_i = '0;
  logic            gnt_i = 1'b0;
  logic            r_valid_i = 1'b0;
  logic [DW-1:0]   r_rdata_i = '0;
  logic            r_opc_i = 1'b0;

  logic [N-1:0]    gnt_o, r_valid_o;
  logic [DW-1:0]   r_rdata_o;
  logic            r_opc_o, req_o, wen_o, err_o;
  logic [AW-1:0]   add_o;
  logic [DW-1:0]   wdata_o;
  logic [BW-1:0]   be_o;
  logic [CW-1:0]   outstanding_o;

  fc_l2_port_arbiter #(
    .N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_i(req_i), .add_i(add_i), .wen_i(wen_i), .wdata_i(wdata_i), .be_i(be_i),
    .gnt_o(gnt_o), .r_valid_o(r_valid_o), .r_rdata_o(r_rdata_o), .r_opc_o(r_opc_o),
    .req_o(req_o), .add_o(add_o), .wen_o(wen_o), .wdata_o(wdata_o), .be_o(be_o),
    .gnt_i(gnt_i), .r_valid_i(r_valid_i), .r_rdata_i(r_rdata_i), .r_opc_i(r_opc_i),
    .outstanding_o(outstanding_o), .err_unexp_rvalid_o(err_o)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: queue of issuer IDs in acceptance order, rotating priority, sticky error.
  int m_q[$];
  int m_ptr = 0;
  bit m_err = 1'b0;

  function automatic int m_winner();
    for (int k = 0; k < N; k++) begin
      if (req_i[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  int c_w;
  bit c_req;
  logic [N-1:0] c_gnt, c_rv;

  always @(negedge clk) begin
    c_w   = m_winner();
    c_req = (c_w >= 0) && (m_q.size() < MO);
    c_gnt = (c_req && gnt_i) ? (N'(1) << c_w) : '0;
    c_rv  = (r_valid_i && m_q.size() > 0) ? (N'(1) << m_q[0]) : '0;
    chk("req_o", 64'(req_o), 64'(c_req));
    chk("gnt_o", 64'(gnt_o), 64'(c_gnt));
    chk("r_valid_o", 64'(r_valid_o), 64'(c_rv));
    chk("r_rdata_o", 64'(r_rdata_o), 64'(r_rdata_i));
    chk("r_opc_o", 64'(r_opc_o), 64'(r_opc_i));
    chk("outstanding_o", 64'(outstanding_o), 64'(m_q.size()));
    chk("err_unexp", 64'(err_o), 64'(m_err));
    if (c_req) begin
      chk("add_o", 64'(add_o), 64'(add_i[c_w*AW +: AW]));
      chk("wdata_o", 64'(wdata_o), 64'(wdata_i[c_w*DW +: DW]));
      chk("be_o", 64'(be_o), 64'(be_i[c_w*BW +: BW]));
      chk("wen_o", 64'(wen_o), 64'(wen_i[c_w]));
    end else begin
      chk("add_o_idle", 64'(add_o), 64'(0));
      chk("wdata_o_idle", 64'(wdata_o), 64'(0));
      chk("be_o_idle", 64'(be_o), 64'(0));
      chk("wen_o_idle", 64'(wen_o), 64'(1));
    end
  end

  int  u_w;
  bit  u_push;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_ptr = 0;
      m_err = 1'b0;
    end else begin
      u_w    = m_winner();
      u_push = (u_w >= 0) && (m_q.size() < MO) && gnt_i;
      if (r_valid_i) begin
        if (m_q.size() > 0) void'(m_q.pop_front());
        else m_err = 1'b1;
      end
      if (u_push) begin
        m_q.push_back(u_w);
        m_ptr = (u_w + 1) % N;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst req_o", 64'(req_o), 64'(0));
    chk("rst gnt_o", 64'(gnt_o), 64'(0));
    chk("rst r_valid_o", 64'(r_valid_o), 64'(0));
    chk("rst add_o", 64'(add_o), 64'(0));
    chk("rst wen_o", 64'(wen_o), 64'(1));
    chk("rst outstanding", 64'(outstanding_o), 64'(0));
    chk("rst err", 64'(err_o), 64'(0));
    tick();
    rst_n = 1'b1;

    // Single read
    req_i = 2'b01; wen_i = 2'b01; add_i[AW-1:0] = 32'h1C00_0100; gnt_i = 1'b1;
    @(negedge clk);
    chk("single gnt_o", 64'(gnt_o), 64'(2'b01));
    chk("single add_o", 64'(add_o), 64'h1C00_0100);
    tick();
    req_i = '0; gnt_i = 1'b0;
    @(negedge clk);
    chk("single outstanding", 64'(outstanding_o), 64'(1));
    tick();
    tick();
    r_valid_i = 1'b1; r_rdata_i = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("single r_valid_o", 64'(r_valid_o), 64'(2'b01));
    chk("single r_rdata_o", 64'(r_rdata_o), 64'hDEAD_BEEF);
    tick();
    r_valid_i = 1'b0;
    @(negedge clk);
    chk("single drained", 64'(outstanding_o), 64'(0));

    // Reset pulse so priority restarts at requester 0
    tick(); rst_n = 1'b0;
    tick(); rst_n = 1'b1;

    // Contention into full
    req_i = 2'b11; wen_i = 2'b11; gnt_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("contend gnt_o", 64'(gnt_o), (i % 2 == 0) ? 64'(2'b01) : 64'(2'b10));
      tick();
    end
    r_valid_i = 1'b1;
    @(negedge clk);
    chk("full outstanding", 64'(outstanding_o), 64'(4));
    chk("full req_o", 64'(req_o), 64'(0));
    chk("full r_valid_o", 64'(r_valid_o), 64'(2'b01));
    tick();
    r_valid_i = 1'b0; gnt_i = 1'b0;
    @(negedge clk);
    chk("after pop outstanding", 64'(outstanding_o), 64'(3));
    chk("after pop req_o", 64'(req_o), 64'(1));
    tick();
    req_i = '0; r_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("contend r_valid_o", 64'(r_valid_o), (i % 2 == 0) ? 64'(2'b10) : 64'(2'b01));
      tick();
    end
    r_valid_i = 1'b0;

    // Backpressure
    req_i = 2'b10; add_i[2*AW-1:AW] = 32'hA5A5_0000; gnt_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp gnt_o", 64'(gnt_o), 64'(0));
      chk("bp add_o", 64'(add_o), 64'hA5A5_0000);
      tick();
    end
    gnt_i = 1'b1;
    @(negedge clk);
    chk("bp gnt_o release", 64'(gnt_o), 64'(2'b10));
    chk("bp add_o release", 64'(add_o), 64'hA5A5_0000);
    tick();
    req_i = '0; gnt_i = 1'b0; r_valid_i = 1'b1;
    @(negedge clk);
    chk("bp r_valid_o", 64'(r_valid_o), 64'(2'b10));
    tick();

    // Unexpected response (count is 0 here)
    @(negedge clk);
    chk("unexp r_valid_o", 64'(r_valid_o), 64'(0));
    tick();
    r_valid_i = 1'b0;
    @(negedge clk);
    chk("unexp err set", 64'(err_o), 64'(1));
    repeat (3) tick();
    @(negedge clk);
    chk("unexp err sticky", 64'(err_o), 64'(1));

    // Reset mid-operation
    tick();
    req_i = 2'b11; gnt_i = 1'b1;
    tick();
    tick();
    req_i = '0; gnt_i = 1'b0;
    @(negedge clk);
    chk("midrst outstanding pre", 64'(outstanding_o), 64'(2));
    #2 rst_n = 1'b0;
    #1;
    chk("midrst outstanding", 64'(outstanding_o), 64'(0));
    chk("midrst err", 64'(err_o), 64'(0));
    tick();
    rst_n = 1'b1; req_i = 2'b11; gnt_i = 1'b1;
    @(negedge clk);
    chk("midrst first gnt", 64'(gnt_o), 64'(2'b01));
    tick();
    req_i = '0; gnt_i = 1'b0;

    // Randomized traffic
    repeat (3000) begin
      req_i     = N'($urandom_range(0, (1 << N) - 1));
      wen_i     = N'($urandom_range(0, (1 << N) - 1));
      add_i     = {$urandom, $urandom};
      wdata_i   = {$urandom, $urandom};
      be_i      = 8'($urandom_range(0, 255));
      gnt_i     = ($urandom_range(0, 3) != 0);
      r_rdata_i = $urandom;
      r_opc_i   = 1'($urandom_range(0, 1));
      if (m_q.size() > 0) r_valid_i = 1'($urandom_range(0, 1));
      else                r_valid_i = ($urandom_range(0, 199) == 0);
      rst_n = ($urandom_range(0, 399) != 0);
      tick();
    end
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fc_l2_port_arbiter.md
# fc_l2_port_arbiter

Round-robin arbiter that shares one FC-side L2 TCDM master port between N requesters, e.g. the FC core data port and a debug/DMA requester. It tracks outstanding reads and writes in an in-order ID FIFO, so every response is routed back to the requester that issued it. It sits in the FC subsystem between the requesters and the l2_data_master bus.

## Interface
Parameters:
- N_REQ, 2, number of requesters (2..8)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width; BE width = DATA_WIDTH/8
- MAX_OUTSTANDING, 4, depth of the response-ID FIFO (power of two, ≥2)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  N_REQ  per-requester request
- add_i  in  N_REQ×ADDR_WIDTH  per-requester address
- wen_i  in  N_REQ  per-requester write-enable, active-low (1 = read)
- wdata_i  in  N_REQ×DATA_WIDTH  per-requester write data
- be_i  in  N_REQ×DATA_WIDTH/8  per-requester byte enables
- gnt_o  out  N_REQ  per-requester grant
- r_valid_o  out  N_REQ  per-requester response valid
- r_rdata_o  out  DATA_WIDTH  response data, broadcast to all requesters
- r_opc_o  out  1  response error, broadcast
- req_o, add_o, wen_o, wdata_o, be_o  out  1/ADDR_WIDTH/1/DATA_WIDTH/DATA_WIDTH/8  master request channel
- gnt_i  in  1  master grant
- r_valid_i, r_rdata_i, r_opc_i  in  1/DATA_WIDTH/1  master response channel, in order
- outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  number of in-flight transactions
- err_unexp_rvalid_o  out  1  sticky flag: r_valid_i seen with no transaction in flight

## Operation
- Handshake: a transaction is accepted on a cycle with req_o & gnt_i. A response is one r_valid_i pulse per accepted transaction, in acceptance order, at least 1 cycle later.
- Arbitration: combinational round-robin over req_i, starting at priority pointer ptr. winner = first requester with req_i set at index ptr, ptr+1, … modulo N_REQ.
- full = (count == MAX_OUTSTANDING).
- req_o = |req_i & ~full. add_o/wen_o/wdata_o/be_o are muxed from winner. When req_o = 0 they are all zero (wen_o = 1).
- gnt_o[winner] = gnt_i & req_o. All other bits of gnt_o are 0.
- On acceptance: push winner ID into the FIFO, and set ptr ← (winner+1) mod N_REQ.
- ptr does not move without an acceptance. A requester holding req_i under gnt_i = 0 keeps its slot, with no starvation reordering.
- Response: r_valid_o[head ID] = r_valid_i when count > 0. r_rdata_o = r_rdata_i and r_opc_o = r_opc_i, passed through unconditionally.
- On r_valid_i with count > 0: pop the head.
- On r_valid_i with count = 0: no pop, all r_valid_o stay 0, and err_unexp_rvalid_o is set to 1 until reset.
- Push and pop in the same cycle: count unchanged and the FIFO stays correct. When full, req_o is 0 even if a pop occurs that cycle, so a push never coincides with full.
- Arithmetic: read/write pointers wrap modulo MAX_OUTSTANDING. count saturates by construction and never exceeds MAX_OUTSTANDING.

## Timing
- Request path is fully combinational (req_i → req_o/gnt_o), with 0 added latency.
- Response routing is combinational (r_valid_i → r_valid_o), with 0 added latency.
- ptr, FIFO, count and the error flag update on the rising edge of clk_i.
- Reset (asynchronous, any time, including mid-transaction) sets ptr = 0, count = 0 and FIFO pointers = 0, and clears err_unexp_rvalid_o to 0.
- Responses outstanding at reset are dropped. Any later r_valid_i for them sets the error flag.
- Output values during reset with req_i = 0:
  - req_o = 0, gnt_o = 0, r_valid_o = 0.
  - add_o/wdata_o/be_o = 0, wen_o = 1.
  - outstanding_o = 0, err_unexp_rvalid_o = 0.

## Test plan
- Single read: req_i = 01, wen_i[0] = 1, add_i[0] = 0x1C000100, gnt_i = 1 → gnt_o = 01 same cycle and outstanding_o = 1. Then r_valid_i with rdata 0xDEADBEEF two cycles later → r_valid_o = 01, r_rdata_o = 0xDEADBEEF, outstanding_o = 0.
- Contention: req_i = 11 held for 4 cycles, gnt_i = 1 → grants alternate 01, 10, 01, 10, and responses are routed in the same order.
- Backpressure: req_i = 10, gnt_i = 0 for 3 cycles, then 1 → gnt_o = 00 for 3 cycles, then 10, with add_o stable throughout.
- Full: MAX_OUTSTANDING = 4, issue 4 accepts with no responses → outstanding_o = 4 and req_o = 0 while req_i ≠ 0. One r_valid_i → outstanding_o = 3 and req_o = 1 the next cycle.
- Unexpected response: r_valid_i with count = 0 → r_valid_o = 00 and err_unexp_rvalid_o = 1, which stays set until rst_ni is asserted.
- Reset mid-operation: 2 outstanding, assert rst_ni = 0 → outstanding_o = 0 immediately. After release, the first grant with req_i = 11 goes to requester 0.
